// File: rtl/mult_pkg.sv
// Shared types and constants for the shared shift-add multiplier controller.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_WIDTH   = 8;
    localparam int DEF_NUM_REQ = 4;

    // Bits needed to index 'value' distinct items (minimum 0).
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/shift_add_core.sv
// Sequential shift-add multiplier: one partial-product step per cycle after start.
// Optional early termination when the remaining multiplier bits are zero: MULT_EARLY_TERM_EN.
module shift_add_core
    import mult_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] prod
);

    localparam int CNT_W = clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] num_reg;
    logic [WIDTH-1:0]   mplier_reg;
    logic [2*WIDTH-1:0] acc_reg;
    logic [CNT_W-1:0]   count_reg;

    logic               running;
    logic               early_stop;
    logic               last_step;
    logic [2*WIDTH-1:0] acc_next;

    assign running  = (count_reg != '0);
    assign acc_next = mplier_reg[0] ? (acc_reg + num_reg) : acc_reg;

`ifdef MULT_EARLY_TERM_EN
    // Nothing left to add once the shifted multiplier is empty.
    assign early_stop = ((mplier_reg >> 1) == '0);
`else
    assign early_stop = 1'b0;
`endif

    assign last_step = running && ((count_reg == CNT_W'(1)) || early_stop);

    // prod is the accumulator value after the current step, so the caller can
    // capture the final product on the same edge the last step completes.
    assign done = last_step;
    assign prod = acc_next;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            num_reg    <= '0;
            mplier_reg <= '0;
            acc_reg    <= '0;
            count_reg  <= '0;
        end else if (start) begin
            num_reg    <= {{WIDTH{1'b0}}, a};
            mplier_reg <= b;
            acc_reg    <= '0;
            count_reg  <= CNT_W'(WIDTH);
        end else if (running) begin
            acc_reg    <= acc_next;
            num_reg    <= num_reg << 1;
            mplier_reg <= mplier_reg >> 1;
            count_reg  <= last_step ? '0 : (count_reg - CNT_W'(1));
        end
    end

endmodule

// File: rtl/mult_share_ctrl.sv
// Round-robin arbiter and sequencer sharing one shift-add multiplier among NUM_REQ clients.
// Build option MULT_EARLY_TERM_EN shortens RUN to the multiplier's significant bits.
module mult_share_ctrl
    import mult_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int WIDTH   = DEF_WIDTH,
    parameter int ID_W    = clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [2*WIDTH-1:0]       rsp_prod,
    output logic [ID_W-1:0]          rsp_id,
    output logic                     busy
);

    state_t             state_reg;
    logic [ID_W-1:0]    rr_ptr_reg;
    logic [ID_W-1:0]    job_id_reg;
    logic               rsp_valid_reg;
    logic [2*WIDTH-1:0] rsp_prod_reg;
    logic [ID_W-1:0]    rsp_id_reg;

    logic               grant_any;
    logic [ID_W-1:0]    grant_idx;
    logic               accept;
    logic               core_done;
    logic [2*WIDTH-1:0] core_prod;
    logic [WIDTH-1:0]   a_arr [NUM_REQ];
    logic [WIDTH-1:0]   b_arr [NUM_REQ];
    logic [ID_W-1:0]    rr_next;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign a_arr[gi] = req_a[gi*WIDTH +: WIDTH];
            assign b_arr[gi] = req_b[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // Scan from the farthest candidate back to rr_ptr so the nearest valid wins.
    always_comb begin
        int idx;
        grant_any = 1'b0;
        grant_idx = '0;
        idx       = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = int'(rr_ptr_reg) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (req_valid[idx]) begin
                grant_any = 1'b1;
                grant_idx = ID_W'(idx);
            end
        end
    end

    assign accept = reset && (state_reg == IDLE) && grant_any;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
            assign req_ready[gi] = accept && (grant_idx == ID_W'(gi));
        end
    endgenerate

    shift_add_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk   (clk),
        .reset (reset),
        .start (accept),
        .a     (a_arr[grant_idx]),
        .b     (b_arr[grant_idx]),
        .done  (core_done),
        .prod  (core_prod)
    );

    assign rr_next = (job_id_reg == ID_W'(NUM_REQ - 1)) ? '0 : (job_id_reg + ID_W'(1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= IDLE;
            rr_ptr_reg    <= '0;
            job_id_reg    <= '0;
            rsp_valid_reg <= 1'b0;
            rsp_prod_reg  <= '0;
            rsp_id_reg    <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (grant_any) begin
                        job_id_reg <= grant_idx;
                        state_reg  <= RUN;
                    end
                end
                RUN: begin
                    if (core_done) begin
                        rsp_valid_reg <= 1'b1;
                        rsp_prod_reg  <= core_prod;
                        rsp_id_reg    <= job_id_reg;
                        state_reg     <= DONE;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        rsp_valid_reg <= 1'b0;
                        rr_ptr_reg    <= rr_next;
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign rsp_valid = rsp_valid_reg;
    assign rsp_prod  = rsp_prod_reg;
    assign rsp_id    = rsp_id_reg;
    assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_mult_share_ctrl.sv
// Randomized scoreboard bench for mult_share_ctrl: driver pushes expected jobs, monitor checks.
module tb_mult_share_ctrl;

    localparam int N   = 4;
    localparam int W   = 8;
    localparam int IDW = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic [N-1:0]     req_valid;
    logic [N*W-1:0]   req_a;
    logic [N*W-1:0]   req_b;
    logic [N-1:0]     req_ready;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [2*W-1:0]   rsp_prod;
    logic [IDW-1:0]   rsp_id;
    logic             busy;

    mult_share_ctrl #(.NUM_REQ(N), .WIDTH(W), .ID_W(IDW)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_prod  (rsp_prod),
        .rsp_id    (rsp_id),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int             id;
        logic [2*W-1:0] prod;
        int             acc_cyc;
        int             runlen;
    } job_t;

    job_t exp_q[$];
    int   acc_log[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    // driver state
    bit [N-1:0]   pend;
    logic [W-1:0] op_a [N];
    logic [W-1:0] op_b [N];
    int           rdy_mode;
    bit           refill;

    // monitor / reference model state
    bit   model_busy;
    int   model_rr;
    bit   have_cur;
    job_t cur;
    bit   spacing_en;
    int   last_acc;
    int   last_runlen;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // RUN length from the multiplier value alone.
    function automatic int run_len(input logic [W-1:0] b);
        int msb_len;
        int r;
        msb_len = 1;
        for (int i = 0; i < W; i++) begin
            if (b[i]) msb_len = i + 1;
        end
        r = W;
`ifdef MULT_EARLY_TERM_EN
        r = msb_len;
`endif
        return r;
    endfunction

    function automatic logic [W-1:0] rand_op();
        case ($urandom_range(0, 3))
            0:       return '0;
            1:       return '1;
            default: return W'($urandom);
        endcase
    endfunction

    task automatic drive();
        req_valid = pend;
        for (int i = 0; i < N; i++) begin
            req_a[i*W +: W] = op_a[i];
            req_b[i*W +: W] = op_b[i];
        end
        case (rdy_mode)
            0:       rsp_ready = 1'b0;
            1:       rsp_ready = 1'b1;
            default: rsp_ready = 1'($urandom_range(0, 1));
        endcase
    endtask

    // One clock: observe acceptance at negedge, update requesters after the edge.
    task automatic cycle();
        logic [N-1:0] acc;
        int           acc_cyc;
        int           p;
        @(negedge clk);
        acc     = req_ready;
        acc_cyc = cyc;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (acc[i]) begin
                p = int'(op_a[i]) * int'(op_b[i]);
                exp_q.push_back('{i, (2*W)'(p), acc_cyc, run_len(op_b[i])});
                acc_log.push_back(i);
                pend[i] = refill;
                if (refill) begin
                    op_a[i] = rand_op();
                    op_b[i] = rand_op();
                end
            end
        end
        drive();
    endtask

    task automatic wait_idle(input int max_cycles);
        int n;
        n = 0;
        while ((pend != '0 || model_busy || have_cur || exp_q.size() != 0) && n < max_cycles) begin
            cycle();
            n++;
        end
        chk("drain_within_budget", 64'(n >= max_cycles), 64'd0);
    endtask

    task automatic send(input int id, input logic [W-1:0] a, input logic [W-1:0] b);
        pend[id] = 1'b1;
        op_a[id] = a;
        op_b[id] = b;
        drive();
        wait_idle(200);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
        chk({tag, "_rsp_prod"},  64'(rsp_prod),  64'd0);
        chk({tag, "_rsp_id"},    64'(rsp_id),    64'd0);
        chk({tag, "_busy"},      64'(busy),      64'd0);
        chk({tag, "_req_ready"}, 64'(req_ready), 64'd0);
    endtask

    // Monitor: reference arbitration, busy, and response contents/timing.
    always @(negedge clk) begin
        logic [N-1:0] exp_rdy;
        bit           found;
        int           idx;
        if (!reset) begin
            model_busy = 1'b0;
            model_rr   = 0;
            have_cur   = 1'b0;
        end else begin
            exp_rdy = '0;
            found   = 1'b0;
            if (!model_busy) begin
                for (int k = 0; k < N; k++) begin
                    idx = (model_rr + k) % N;
                    if (req_valid[idx] && !found) begin
                        exp_rdy[idx] = 1'b1;
                        found = 1'b1;
                    end
                end
            end
            chk("req_ready", 64'(req_ready), 64'(exp_rdy));
            chk("busy", 64'(busy), 64'(model_busy));
            if (model_busy) begin
                if (!have_cur) begin
                    if (exp_q.size() > 0) begin
                        cur      = exp_q.pop_front();
                        have_cur = 1'b1;
                    end else begin
                        chk("job_record_present", 64'd0, 64'd1);
                    end
                end
                if (have_cur) begin
                    chk("rsp_valid_timing", 64'(rsp_valid),
                        64'(cyc >= cur.acc_cyc + cur.runlen + 1));
                    if (rsp_valid) begin
                        chk("rsp_prod", 64'(rsp_prod), 64'(cur.prod));
                        chk("rsp_id", 64'(rsp_id), 64'(cur.id));
                        if (rsp_ready) begin
                            $display("cycle %0d: rsp id=%0d prod=%0d (accepted cycle %0d)",
                                     cyc, rsp_id, rsp_prod, cur.acc_cyc);
                            model_busy  = 1'b0;
                            model_rr    = (cur.id + 1) % N;
                            last_runlen = cur.runlen;
                            have_cur    = 1'b0;
                        end
                    end
                end
            end else begin
                chk("rsp_valid_idle", 64'(rsp_valid), 64'd0);
            end
            if (exp_rdy != '0) begin
                if (spacing_en && last_acc >= 0) begin
                    chk("accept_spacing", 64'(cyc - last_acc), 64'(last_runlen + 2));
                end
                last_acc   = cyc;
                model_busy = 1'b1;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int start_cnt;
        reset      = 1'b0;
        pend       = '0;
        refill     = 1'b0;
        rdy_mode   = 1;
        spacing_en = 1'b0;
        last_acc   = -1;
        for (int i = 0; i < N; i++) begin
            op_a[i] = '0;
            op_b[i] = '0;
        end
        drive();
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        reset = 1'b1;
        drive();

        // directed products
        send(1, 8'd13, 8'd11);
        send(0, 8'd255, 8'd255);
        send(0, 8'd7, 8'd1);
        send(1, 8'd7, 8'd0);
        send(3, 8'd0, 8'd200);

        // all requesters always valid, consumer always ready
        refill     = 1'b1;
        spacing_en = 1'b1;
        last_acc   = -1;
        for (int i = 0; i < N; i++) begin
            pend[i] = 1'b1;
            op_a[i] = W'($urandom);
            op_b[i] = W'($urandom) | 8'h80;
        end
        drive();
        start_cnt = acc_log.size();
        n = 0;
        while (acc_log.size() - start_cnt < 5 && n < 100) begin
            cycle();
            n++;
        end
        chk("five_grants_issued", 64'(acc_log.size() - start_cnt >= 5), 64'd1);
        refill     = 1'b0;
        spacing_en = 1'b0;
        wait_idle(200);

        // consumer stalls in DONE while another requester waits
        rdy_mode = 0;
        pend[3] = 1'b1; op_a[3] = 8'd99; op_b[3] = 8'd77;
        drive();
        n = 0;
        while (!rsp_valid && n < 40) begin
            cycle();
            n++;
        end
        chk("stall_rsp_valid_seen", 64'(rsp_valid), 64'd1);
        pend[2] = 1'b1; op_a[2] = 8'd5; op_b[2] = 8'd6;
        drive();
        repeat (20) cycle();
        rdy_mode = 1;
        drive();
        wait_idle(200);

        // reset four cycles into RUN
        pend[2] = 1'b1; op_a[2] = 8'd45; op_b[2] = 8'd67;
        drive();
        start_cnt = acc_log.size();
        n = 0;
        while (acc_log.size() == start_cnt && n < 40) begin
            cycle();
            n++;
        end
        repeat (3) cycle();
        for (int i = 0; i < N; i++) begin
            pend[i] = 1'b1;
            op_a[i] = W'($urandom);
            op_b[i] = W'($urandom);
        end
        drive();
        #2;
        reset = 1'b0;
        #1;
        check_reset_outputs("midrun_reset");
        exp_q.delete();
        acc_log.delete();
        @(negedge clk);
        @(negedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        wait_idle(300);
        chk("first_grant_after_reset", 64'(acc_log.size() > 0 ? acc_log[0] : -1), 64'd0);

        // randomized traffic with a random consumer
        rdy_mode = 2;
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    pend[i] = 1'b1;
                    op_a[i] = rand_op();
                    op_b[i] = rand_op();
                end
            end
            drive();
            cycle();
        end
        rdy_mode = 1;
        drive();
        wait_idle(400);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mult_share_ctrl.md
Name: mult_share_ctrl

Overview:
- Round-robin arbiter and sequencer that shares one sequential shift-add multiplier among NUM_REQ requesters.
- Accepts one operand pair at a time over valid/ready and runs the WIDTH-cycle shift-add sequence.
- Returns the full 2*WIDTH product tagged with the requester index, holding it until the consumer accepts.
- Sits between several datapath clients and the single multiplier resource.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- WIDTH, 8, operand width in bits; product is 2*WIDTH bits.
- ID_W, 2, requester-index width, equal to clog2(NUM_REQ).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester operand valid.
- req_a  in  NUM_REQ*WIDTH  multiplicands, requester i in slice [i*WIDTH +: WIDTH].
- req_b  in  NUM_REQ*WIDTH  multipliers, same slicing.
- req_ready  out  NUM_REQ  one-hot accept strobe.
- rsp_valid  out  1  product available.
- rsp_ready  in  1  consumer accepts product.
- rsp_prod  out  2*WIDTH  unsigned product.
- rsp_id  out  ID_W  index of requester that owns rsp_prod.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (asynchronous, reset=0):
  - State=IDLE, rr_ptr=0.
  - rsp_valid=0, rsp_prod=0, rsp_id=0, busy=0, req_ready=0.
  - Internal num, mplier, count, acc cleared.
  - Reset mid-operation discards the job; no response is produced.
- IDLE:
  - If any req_valid is high, pick g = first valid index at or after rr_ptr, wrapping modulo NUM_REQ.
  - req_ready[g]=1 combinationally in this cycle only; the transfer occurs at this edge.
  - At the edge: num={WIDTH zeros, req_a[g]}, mplier=req_b[g], acc=0, id=g, count=WIDTH; next state RUN.
  - If no req_valid is high, stay in IDLE with req_ready=0.
- RUN, each cycle:
  - If mplier[0], acc<=acc+num. Sum is 2*WIDTH bits wide; the num register is 2*WIDTH bits wide, so no truncation.
  - num<<=1; mplier>>=1; count<=count-1.
  - When count==1, go to DONE.
  - RUN lasts exactly WIDTH cycles.
- DONE:
  - rsp_valid=1; rsp_prod=acc and rsp_id=id, both held stable.
  - When rsp_ready=1: rsp_valid drops at the next edge, rr_ptr<=(id+1) mod NUM_REQ, next state IDLE.
- Latency and throughput:
  - rsp_valid rises WIDTH+1 cycles after the accept edge.
  - Minimum spacing between accepts is WIDTH+2 cycles.
- Handshake rules:
  - req_ready is never high outside IDLE and never high for more than one bit.
  - Requesters must hold req_valid and operands stable until they see req_ready.
  - rsp_ready while rsp_valid=0 is ignored.
  - req_valid arriving during RUN/DONE waits; there is no queuing beyond the requester's own hold.
- Fairness: a requester that keeps req_valid asserted is granted within NUM_REQ jobs.
- Boundary cases:
  - Operand 0 still takes the full WIDTH cycles unless the optional feature is enabled.
  - Max operands give no overflow: (2^WIDTH-1)^2 fits in 2*WIDTH bits.

Optional Feature:
- Macro: MULT_EARLY_TERM_EN.
- Defined: in RUN, if next mplier (mplier>>1) is 0, or mplier is 0 on entry, go to DONE after the current cycle.
  - RUN length = max(1, index of highest set bit of B + 1).
  - B=0 gives 1 RUN cycle, product 0.
- Undefined: RUN is always exactly WIDTH cycles.
- Product and rsp_id are identical in both builds.

Decomposition:
- Package mult_pkg:
  - State enum {IDLE, RUN, DONE}.
  - Default WIDTH/NUM_REQ constants.
  - clog2 helper function for ID_W.
- Sub-module shift_add_core:
  - Holds num/mplier/acc/count.
  - Ports: start, a, b, done, prod.
- mult_share_ctrl keeps the FSM, the round-robin arbiter, and the response register.

Test Plan:
- Reset, then requester 1 sends A=13, B=11 → req_ready=0010 for one cycle; rsp_valid after 9 cycles; rsp_prod=143, rsp_id=1.
- A=255, B=255 → rsp_prod=0xFE01 (65025), no truncation.
- All four req_valid held high, rsp_ready tied 1 → grants in order 0,1,2,3,0; each req_ready one-hot; accepts spaced 10 cycles apart.
- rsp_ready held 0 for 20 cycles in DONE → rsp_valid, rsp_prod, rsp_id stable; busy=1; no req_ready pulses; release → IDLE next cycle.
- Assert reset 4 cycles into RUN → all outputs 0 immediately; no rsp_valid afterward; next grant starts at index 0.
- With MULT_EARLY_TERM_EN: A=7, B=1 → rsp_valid 2 cycles after accept, prod 7; B=0 → prod 0, same 2-cycle latency; without the macro both take 9 cycles.
